mem_stage_bus_ctrl: RTL
=======================

Name: mem_stage_bus_ctrl

Overview:
- Memory-access (MEM) stage controller for the 5-stage core.
- Sits between the EX/MEM stage register and the MEM/WB stage register.
- Turns the decoded load/store in the EX/MEM register into one word-aligned bus transaction with byte enables, and holds the pipeline (stall) until the bus acknowledges or a timeout fires.
- Returns right-aligned load data for the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles without bus_ack before the transaction is aborted. 0 disables the timeout.

Ports:
- clk  in  1  core clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- addr  in  32  effective address (EX/MEM alu_result)
- wdata  in  32  store data (EX/MEM mem_write_data)
- mem_read  in  1  load in MEM stage
- mem_write  in  1  store in MEM stage
- acc_mode  in  2  00=word, 01=half, 10=byte, 11=treated as word
- bus_req  out  1  transaction request, registered
- bus_we  out  1  1=write, registered
- bus_addr  out  32  {addr[31:2],2'b00}, registered
- bus_be  out  4  byte enables, registered
- bus_wdata  out  32  lane-replicated store data, registered
- bus_ack  in  1  single-cycle completion from slave
- bus_rdata  in  32  read data, valid with bus_ack
- mem_data  out  32  load lane, right-aligned, zero-extended, registered
- stall  out  1  freeze PC and all stage registers, combinational
- misalign  out  1  one-cycle pulse: misaligned access dropped
- bus_timeout  out  1  one-cycle pulse: transaction aborted

Behaviour:
- Reset values (asynchronous): state=IDLE, wait counter=0, and every registered output = 0 (bus_req, bus_we, bus_addr, bus_be, bus_wdata, mem_data, misalign, bus_timeout).
- op = mem_read | mem_write. If both are set, the access is a write.
- Alignment:
  - half is misaligned when addr[0]=1
  - word (or mode 11) is misaligned when addr[1:0]!=0
  - byte is never misaligned
- Lanes are little-endian, indexed by addr[1:0].
- bus_be:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1]?4'b1100:4'b0011
  - word: 4'b1111
- bus_wdata:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction on ack: the selected lane is shifted to bit 0 and zero-filled above. Sign extension is done in write-back using acc_mode.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - op & aligned: load bus_* registers, bus_req<=1, counter<=0, go to REQ.
  - op & misaligned: misalign<=1 for one cycle, no bus activity, go to DONE.
  - !op: stay in IDLE.
- REQ:
  - bus_req stays high and bus_* stay stable until ack.
  - bus_ack: bus_req<=0; on a read, mem_data<=extracted lane; go to DONE.
  - No ack, TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: bus_req<=0, bus_timeout<=1, mem_data<=0, go to DONE.
  - Otherwise counter increments, saturating.
- DONE: exactly one cycle, then IDLE. On the following cycle IDLE evaluates the new EX/MEM contents, so back-to-back memory ops cost 3 cycles each with a 1-cycle-ack slave.
- stall = op & (state!=DONE). This covers the IDLE cycle in which the op is first seen, and all of REQ.
- A misaligned access stalls exactly 1 cycle; its mem_data is not updated.
- Writes never modify mem_data.
- bus_ack outside REQ is ignored.
- Reset mid-REQ drops bus_req immediately. The slave must tolerate an abandoned request.
- The op inputs are stable while stall=1, because the EX/MEM register is frozen; the block does not re-sample them in REQ.

Decomposition:
- Shared package holds:
  - acc_mode encodings (ACC_WORD, ACC_HALF, ACC_BYTE)
  - FSM state encoding (2-bit)
- One combinational sub-module is natural: mem_lane_align. It computes bus_be, bus_wdata, the misaligned flag and load-lane extraction from addr[1:0], acc_mode and data.
- Write-back reuses mem_lane_align's constants for sign extension.

Test Plan:
- Word load at 0x100, slave acks after 2 REQ cycles with rdata 0xDEADBEEF -> bus_addr=0x100, be=4'b1111, stall high 3 cycles then low in DONE, mem_data=0xDEADBEEF.
- Byte store wdata=0x12345678 at 0x203, 1-cycle ack -> be=4'b1000, bus_wdata=0x78787878, bus_we=1, mem_data unchanged.
- Half load at 0x302 with rdata 0xABCD1234 -> be=4'b1100, mem_data=0x0000ABCD; half load at 0x301 -> misalign pulse, stall 1 cycle, bus_req never asserted.
- TIMEOUT_CYCLES=4, no ack -> bus_req high exactly 4 cycles, bus_timeout pulse, mem_data=0, stall released in DONE.
- Two back-to-back word loads (0x10 then 0x14) with 1-cycle acks -> two distinct requests, stall pattern 1,1,0,1,1,0, mem_data updated per load.
- reset_n low during REQ -> bus_req, bus_* and stall go 0 asynchronously; after release, state is IDLE and a stray bus_ack is ignored.

Source files
------------

// File: rtl/mem_stage_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage bus controller: access-size encodings,
// FSM state encoding, byte-enable constants and the write-back extension helper.
package mem_stage_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        ACC_WORD     = 2'b00,
        ACC_HALF     = 2'b01,
        ACC_BYTE     = 2'b10,
        ACC_WORD_ALT = 2'b11
    } acc_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    // Write-back sign/zero extension of a right-aligned load lane.
    function automatic logic [31:0] wb_extend(input logic [31:0] lane,
                                              input logic [1:0]  mode,
                                              input logic        is_unsigned);
        logic [31:0] res;
        res = lane;
        case (acc_mode_e'(mode))
            ACC_HALF: res = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
            ACC_BYTE: res = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
            default:  res = lane;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_stage_bus_ctrl_if.sv
// Word-aligned single-outstanding data bus between the MEM stage and memory.
interface mem_stage_bus_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage_bus_ctrl_lane_align.sv
// Byte-lane steering: byte enables, store-data replication, alignment check
// and right-aligned, zero-extended load-lane extraction.
module mem_lane_align
    import mem_stage_bus_ctrl_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  acc_mode,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic [31:0] rdata_lane
);

    // Per-size lane selection; mode 11 falls into the word default.
    always_comb begin
        be         = BE_WORD;
        wdata_rep  = wdata;
        misaligned = (addr_lo != 2'b00);
        rdata_lane = rdata;
        case (acc_mode_e'(acc_mode))
            ACC_HALF: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
                rdata_lane = {16'h0000, (addr_lo[1] ? rdata[31:16] : rdata[15:0])};
            end
            ACC_BYTE: begin
                be         = BE_BYTE0 << addr_lo;
                wdata_rep  = {4{wdata[7:0]}};
                misaligned = 1'b0;
                case (addr_lo)
                    2'd0:    rdata_lane = {24'h000000, rdata[7:0]};
                    2'd1:    rdata_lane = {24'h000000, rdata[15:8]};
                    2'd2:    rdata_lane = {24'h000000, rdata[23:16]};
                    default: rdata_lane = {24'h000000, rdata[31:24]};
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_bus_ctrl.sv
// MEM-stage controller: turns the EX/MEM load/store into one bus transaction,
// stalls the pipeline until ack or timeout, and returns the load lane.
module mem_stage_bus_ctrl
    import mem_stage_bus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 wdata,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [1:0]                  acc_mode,
    mem_stage_bus_ctrl_if.master        bus,
    output logic [31:0]                 mem_data,
    output logic                        stall,
    output logic                        misalign,
    output logic                        bus_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_req_q, bus_req_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [31:0]        mem_data_q, mem_data_d;
    logic               misalign_q, misalign_d;
    logic               bus_timeout_q, bus_timeout_d;

    logic               op;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic               lane_misaligned;
    logic [31:0]        lane_rdata;

    assign op = mem_read | mem_write;

    mem_lane_align u_lane_align (
        .addr_lo    (addr[1:0]),
        .acc_mode   (acc_mode),
        .wdata      (wdata),
        .rdata      (bus.bus_rdata),
        .be         (lane_be),
        .wdata_rep  (lane_wdata),
        .misaligned (lane_misaligned),
        .rdata_lane (lane_rdata)
    );

    // Next-state and registered-output logic for the IDLE/REQ/DONE sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        mem_data_d    = mem_data_q;
        misalign_d    = 1'b0;
        bus_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (lane_misaligned) begin
                        misalign_d = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = lane_be;
                        bus_wdata_d = lane_wdata;
                        cnt_d       = '0;
                        state_d     = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.bus_ack) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        mem_data_d = lane_rdata;
                    end
                    state_d = ST_DONE;
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    bus_req_d     = 1'b0;
                    bus_timeout_d = 1'b1;
                    mem_data_d    = '0;
                    state_d       = ST_DONE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs, cleared asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            mem_data_q    <= '0;
            misalign_q    <= 1'b0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            mem_data_q    <= mem_data_d;
            misalign_q    <= misalign_d;
            bus_timeout_q <= bus_timeout_d;
        end
    end

    // Stall is released in DONE; it is also held low while reset is asserted
    // so the frozen pipeline does not keep a reset core stalled.
    assign stall = reset_n & op & (state_q != ST_DONE);

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign mem_data      = mem_data_q;
    assign misalign      = misalign_q;
    assign bus_timeout   = bus_timeout_q;

endmodule
